// File: rtl/joy_spi_reader_pkg.sv
// Shared definitions for the joystick SPI poller: FSM encoding, command
// prefix, reset centre value and counter width.
package joy_spi_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int         CNT_W          = 20;
  localparam logic [5:0] LED_CMD_PREFIX = 6'b100000;
  localparam logic [9:0] JOY_CENTRE     = 10'd512;
  localparam logic [2:0] LAST_BYTE      = 3'd4;

  // Only byte 0 carries the command; the remaining four clock out zeros.
  function automatic logic [7:0] tx_byte_for(input logic [2:0] idx, input logic [1:0] led_req);
    return (idx == 3'd0) ? {LED_CMD_PREFIX, led_req} : 8'h00;
  endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// One SPI mode-0 byte: generates 8 sclk periods, shifts mosi out MSB first
// on falling edges, samples miso on rising edges, pulses done at the end.
module spi_byte_shift
  import joy_spi_reader_pkg::*;
#(
  parameter int SCLK_HALF = 100
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);

  logic             active_reg;
  logic [CNT_W-1:0] half_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [6:0]       tx_sr_reg;
  logic [7:0]       rx_sr_reg;
  logic [7:0]       rx_byte_reg;
  logic             sclk_reg;
  logic             mosi_reg;
  logic             done_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      active_reg   <= 1'b0;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_sr_reg    <= '0;
      rx_sr_reg    <= '0;
      rx_byte_reg  <= '0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (!active_reg) begin
        if (start) begin
          // MSB goes out immediately so it is stable a full half period
          // before the first rising edge.
          active_reg   <= 1'b1;
          half_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          tx_sr_reg    <= tx_byte[6:0];
          mosi_reg     <= tx_byte[7];
          sclk_reg     <= 1'b0;
        end
      end else if (half_cnt_reg == HALF_LAST) begin
        half_cnt_reg <= '0;
        if (!sclk_reg) begin
          sclk_reg  <= 1'b1;
          rx_sr_reg <= {rx_sr_reg[6:0], miso};
        end else begin
          sclk_reg <= 1'b0;
          if (bit_cnt_reg == 3'd7) begin
            active_reg  <= 1'b0;
            done_reg    <= 1'b1;
            rx_byte_reg <= rx_sr_reg;
            mosi_reg    <= 1'b0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            mosi_reg    <= tx_sr_reg[6];
            tx_sr_reg   <= {tx_sr_reg[5:0], 1'b0};
          end
        end
      end else begin
        half_cnt_reg <= half_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign sclk    = sclk_reg;
  assign mosi    = mosi_reg;
  assign rx_byte = rx_byte_reg;
  assign done    = done_reg;

endmodule

// File: rtl/joy_spi_reader.sv
// Periodic 5-byte SPI poll of an analogue joystick; publishes X/Y/buttons
// atomically once per completed transaction.
module joy_spi_reader
  import joy_spi_reader_pkg::*;
#(
  parameter int SCLK_HALF   = 100,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,   // must be >= 2
  parameter int POLL_PERIOD = 1_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] led,
  input  logic       miso,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic [9:0] joy_x,
  output logic [9:0] joy_y,
  output logic [2:0] btn,
  output logic       sample_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);
  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_PERIOD - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] timer_reg;
  logic [CNT_W-1:0] poll_cnt_reg;
  logic [2:0]       byte_cnt_reg;
  logic             pending_reg;
  logic             ss_reg;
  logic [1:0]       led_lat_reg;
  logic [9:0]       joy_x_reg;
  logic [9:0]       joy_y_reg;
  logic [2:0]       btn_reg;
  logic             sample_valid_reg;

  // Shadow bytes for X/Y; only the bits that reach the outputs are kept.
  logic [7:0] shadow_lo_reg [2];
  logic [1:0] shadow_hi_reg [2];

  logic       poll_wrap;
  logic       start_shift;
  logic       shift_done;
  logic       shadow_we;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;

  assign poll_wrap = (poll_cnt_reg == POLL_LAST);
  assign tx_byte   = tx_byte_for(byte_cnt_reg, led_lat_reg);
  assign shadow_we = (state_reg == ST_SHIFT) && shift_done && (byte_cnt_reg != LAST_BYTE);

  // Launch the shifter on the last SETUP/GAP cycle so the byte starts with
  // no extra dead clock.
  always_comb begin
    start_shift = 1'b0;
    if ((state_reg == ST_SETUP) && (timer_reg == SETUP_LAST))
      start_shift = 1'b1;
    if ((state_reg == ST_GAP) && (timer_reg == GAP_LAST))
      start_shift = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      poll_cnt_reg <= '0;
    else
      poll_cnt_reg <= poll_wrap ? '0 : poll_cnt_reg + CNT_W'(1);
  end

  spi_byte_shift #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shift (
    .clk     (clk),
    .clr     (clr),
    .start   (start_shift),
    .tx_byte (tx_byte),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .rx_byte (rx_byte),
    .done    (shift_done)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          shadow_lo_reg[gi] <= '0;
          shadow_hi_reg[gi] <= '0;
        end else if (shadow_we) begin
          if (byte_cnt_reg == 3'(2 * gi))
            shadow_lo_reg[gi] <= rx_byte;
          if (byte_cnt_reg == 3'(2 * gi + 1))
            shadow_hi_reg[gi] <= rx_byte[1:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg        <= ST_IDLE;
      timer_reg        <= '0;
      byte_cnt_reg     <= '0;
      pending_reg      <= 1'b0;
      ss_reg           <= 1'b1;
      led_lat_reg      <= '0;
      joy_x_reg        <= JOY_CENTRE;
      joy_y_reg        <= JOY_CENTRE;
      btn_reg          <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (poll_wrap && (state_reg != ST_IDLE))
        pending_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (poll_wrap || pending_reg) begin
            pending_reg  <= 1'b0;
            ss_reg       <= 1'b0;
            led_lat_reg  <= led;
            timer_reg    <= '0;
            byte_cnt_reg <= '0;
            state_reg    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (start_shift)
            state_reg <= ST_SHIFT;
          else
            timer_reg <= timer_reg + CNT_W'(1);
        end

        ST_SHIFT: begin
          if (shift_done) begin
            if (byte_cnt_reg == LAST_BYTE) begin
              // Button byte is used straight from the shifter; everything
              // else comes from the shadows, so all fields change together.
              ss_reg           <= 1'b1;
              joy_x_reg        <= {shadow_hi_reg[0], shadow_lo_reg[0]};
              joy_y_reg        <= {shadow_hi_reg[1], shadow_lo_reg[1]};
              btn_reg          <= rx_byte[2:0];
              sample_valid_reg <= 1'b1;
              state_reg        <= ST_DONE;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
              // The done-pulse cycle already counts as the first gap cycle.
              timer_reg    <= CNT_W'(1);
              state_reg    <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (start_shift)
            state_reg <= ST_SHIFT;
          else
            timer_reg <= timer_reg + CNT_W'(1);
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ss           = ss_reg;
  assign joy_x        = joy_x_reg;
  assign joy_y        = joy_y_reg;
  assign btn          = btn_reg;
  assign sample_valid = sample_valid_reg;
  assign busy         = ~ss_reg | pending_reg;

endmodule

// File: tb/tb_joy_spi_reader.sv
// Bench for joy_spi_reader: joystick slave model on miso, mosi/timing
// monitor, expected samples queued per transaction and checked on output.
module tb_joy_spi_reader;

  localparam int SCLK_HALF   = 100;
  localparam int SS_SETUP    = 1500;
  localparam int BYTE_GAP    = 1000;
  localparam int POLL_PERIOD = 5000;

  logic       clk  = 1'b0;
  logic       clr  = 1'b0;
  logic [1:0] led  = 2'b00;
  logic       miso = 1'b0;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic [9:0] joy_x;
  logic [9:0] joy_y;
  logic [2:0] btn;
  logic       sample_valid;
  logic       busy;

  always #5 clk = ~clk;

  joy_spi_reader #(
    .SCLK_HALF   (SCLK_HALF),
    .SS_SETUP    (SS_SETUP),
    .BYTE_GAP    (BYTE_GAP),
    .POLL_PERIOD (POLL_PERIOD)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .led          (led),
    .miso         (miso),
    .ss           (ss),
    .sclk         (sclk),
    .mosi         (mosi),
    .joy_x        (joy_x),
    .joy_y        (joy_y),
    .btn          (btn),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  logic [22:0] exp_q[$];        // {x, y, btn}
  logic [39:0] next_frame = '0; // what the joystick returns next transaction

  // Joystick model and bus monitor, all on the falling clk edge.
  int          cyc          = 0;
  int          ss_fall_cnt  = 0;
  int          ss_fall_cyc  = 0;
  int          ss_rise_cyc  = 0;
  int          ss_high_last = 0;
  int          rise_cnt     = 0;
  int          txn_rises    = 0;
  int          sv_cnt       = 0;
  int          rise_cyc[40];
  logic [39:0] miso_sr   = '0;
  logic [39:0] mosi_sr   = '0;
  logic        prev_ss   = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_ss && !ss) begin
      ss_fall_cnt++;
      ss_fall_cyc  = cyc;
      ss_high_last = cyc - ss_rise_cyc;
      rise_cnt     = 0;
      mosi_sr      = '0;
      miso_sr      = next_frame;
      miso         = next_frame[39];
    end
    if (!prev_ss && ss) begin
      ss_rise_cyc = cyc;
      txn_rises   = rise_cnt;
    end
    if (!ss && sclk && !prev_sclk) begin
      if (rise_cnt < 40) rise_cyc[rise_cnt] = cyc;
      mosi_sr = {mosi_sr[38:0], mosi};
      rise_cnt++;
    end
    if (!ss && !sclk && prev_sclk) begin
      miso_sr = {miso_sr[38:0], 1'b0};
      miso    = miso_sr[39];
    end
    if (sample_valid) sv_cnt++;
    prev_ss   = ss;
    prev_sclk = sclk;
  end

  function automatic logic [39:0] make_frame(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] b, input bit fill);
    logic [5:0] f6;
    logic [4:0] f5;
    f6 = fill ? 6'h3F : 6'h00;
    f5 = fill ? 5'h1F : 5'h00;
    return {x[7:0], f6, x[9:8], y[7:0], f6, y[9:8], f5, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ss_fall(input int budget, output bit ok);
    int start_cnt;
    start_cnt = ss_fall_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ss_fall_cnt != start_cnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sample(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) tick();
    n_checks++; if (ss !== 1'b1) $display("FAIL reset_ss: got %b want 1", ss); else n_pass++;
    n_checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else n_pass++;
    n_checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi); else n_pass++;
    n_checks++; if (joy_x !== 10'd512) $display("FAIL reset_joy_x: got %0d want 512", joy_x); else n_pass++;
    n_checks++; if (joy_y !== 10'd512) $display("FAIL reset_joy_y: got %0d want 512", joy_y); else n_pass++;
    n_checks++; if (btn !== 3'd0) $display("FAIL reset_btn: got %0d want 0", btn); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_sample_valid: got %b want 0", sample_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_first_transaction();
    bit ok;
    int sv_before;
    logic [22:0] exp;
    next_frame = make_frame(10'h2A5, 10'h0C3, 3'b101, 1'b0);
    exp_q.push_back({10'd677, 10'd195, 3'd5});
    led = 2'b10;
    sv_before = sv_cnt;
    clr = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL first_busy_idle: got %b want 0", busy); else n_pass++;
    wait_ss_fall(POLL_PERIOD + 100, ok);
    n_checks++; if (!ok) $display("FAIL first_ss_fall: got timeout want ss fall"); else n_pass++;
    repeat (2000) tick();
    n_checks++; if (joy_x !== 10'd512) $display("FAIL first_mid_joy_x: got %0d want 512", joy_x); else n_pass++;
    led = 2'b01;
    wait_sample(20000, ok);
    n_checks++; if (!ok) $display("FAIL first_sample: got timeout want sample_valid"); else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL first_queue: got empty want 1 entry");
    end else begin
      n_pass++;
      exp = exp_q.pop_front();
      n_checks++; if (joy_x !== exp[22:13]) $display("FAIL first_joy_x: got %0d want %0d", joy_x, exp[22:13]); else n_pass++;
      n_checks++; if (joy_y !== exp[12:3]) $display("FAIL first_joy_y: got %0d want %0d", joy_y, exp[12:3]); else n_pass++;
      n_checks++; if (btn !== exp[2:0]) $display("FAIL first_btn: got %0d want %0d", btn, exp[2:0]); else n_pass++;
    end
    n_checks++; if (busy !== 1'b1) $display("FAIL first_busy_pending: got %b want 1", busy); else n_pass++;
    n_txn++;
    $display("txn %0d: joy_x=%0d joy_y=%0d btn=%0d", n_txn, joy_x, joy_y, btn);
    tick();
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL first_sv_width: got %b want 0", sample_valid); else n_pass++;
    n_checks++; if (sv_cnt - sv_before != 1) $display("FAIL first_sv_count: got %0d want 1", sv_cnt - sv_before); else n_pass++;
    n_checks++; if (txn_rises != 40) $display("FAIL first_rises: got %0d want 40", txn_rises); else n_pass++;
    n_checks++; if (mosi_sr[39:32] !== 8'h82) $display("FAIL first_mosi_b0: got %h want 82", mosi_sr[39:32]); else n_pass++;
    n_checks++; if (mosi_sr[31:0] !== 32'h0) $display("FAIL first_mosi_rest: got %h want 0", mosi_sr[31:0]); else n_pass++;
    n_checks++; if (rise_cyc[0] - ss_fall_cyc != SS_SETUP + SCLK_HALF)
      $display("FAIL first_setup_time: got %0d want %0d", rise_cyc[0] - ss_fall_cyc, SS_SETUP + SCLK_HALF); else n_pass++;
    n_checks++; if (rise_cyc[1] - rise_cyc[0] != 2 * SCLK_HALF)
      $display("FAIL first_sclk_period: got %0d want %0d", rise_cyc[1] - rise_cyc[0], 2 * SCLK_HALF); else n_pass++;
    // Last rise of a byte to first rise of the next: high half + gap + low half.
    n_checks++; if (rise_cyc[8] - rise_cyc[7] != 2 * SCLK_HALF + BYTE_GAP)
      $display("FAIL first_byte_gap: got %0d want %0d", rise_cyc[8] - rise_cyc[7], 2 * SCLK_HALF + BYTE_GAP); else n_pass++;
    n_checks++; if (rise_cyc[39] - rise_cyc[32] != 14 * SCLK_HALF)
      $display("FAIL first_last_byte_span: got %0d want %0d", rise_cyc[39] - rise_cyc[32], 14 * SCLK_HALF); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [22:0] exp;
    next_frame = make_frame(10'd1023, 10'd0, 3'b011, 1'b1);
    exp_q.push_back({10'd1023, 10'd0, 3'd3});
    wait_ss_fall(100, ok);
    n_checks++; if (!ok) $display("FAIL b2b_pending_start: got timeout want ss fall"); else n_pass++;
    n_checks++; if (ss_high_last != 2) $display("FAIL b2b_ss_high: got %0d want 2", ss_high_last); else n_pass++;
    wait_sample(20000, ok);
    n_checks++; if (!ok) $display("FAIL b2b_sample: got timeout want sample_valid"); else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL b2b_queue: got empty want 1 entry");
    end else begin
      n_pass++;
      exp = exp_q.pop_front();
      n_checks++; if (joy_x !== exp[22:13]) $display("FAIL b2b_joy_x: got %0d want %0d", joy_x, exp[22:13]); else n_pass++;
      n_checks++; if (joy_y !== exp[12:3]) $display("FAIL b2b_joy_y: got %0d want %0d", joy_y, exp[12:3]); else n_pass++;
      n_checks++; if (btn !== exp[2:0]) $display("FAIL b2b_btn: got %0d want %0d", btn, exp[2:0]); else n_pass++;
    end
    n_txn++;
    $display("txn %0d: joy_x=%0d joy_y=%0d btn=%0d", n_txn, joy_x, joy_y, btn);
    tick();
    n_checks++; if (mosi_sr[39:32] !== 8'h81) $display("FAIL b2b_mosi_b0: got %h want 81", mosi_sr[39:32]); else n_pass++;
    n_checks++; if (txn_rises != 40) $display("FAIL b2b_rises: got %0d want 40", txn_rises); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int sv_before;
    next_frame = make_frame(10'h3C3, 10'h155, 3'b110, 1'b0);
    exp_q.push_back({10'h3C3, 10'h155, 3'd6});
    wait_ss_fall(100, ok);
    n_checks++; if (!ok) $display("FAIL mid_ss_fall: got timeout want ss fall"); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (rise_cnt >= 20) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("FAIL mid_reach_byte2: got %0d rises want 20", rise_cnt); else n_pass++;
    #1 clr = 1'b0;
    #1;
    n_checks++; if (ss !== 1'b1) $display("FAIL mid_ss: got %b want 1", ss); else n_pass++;
    n_checks++; if (sclk !== 1'b0) $display("FAIL mid_sclk: got %b want 0", sclk); else n_pass++;
    n_checks++; if (joy_x !== 10'd512) $display("FAIL mid_joy_x: got %0d want 512", joy_x); else n_pass++;
    n_checks++; if (joy_y !== 10'd512) $display("FAIL mid_joy_y: got %0d want 512", joy_y); else n_pass++;
    n_checks++; if (btn !== 3'd0) $display("FAIL mid_btn: got %0d want 0", btn); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    // The aborted transaction never produces a sample.
    exp_q.delete();
    sv_before = sv_cnt;
    repeat (10) tick();
    clr = 1'b1;
    repeat (200) tick();
    n_checks++; if (sv_cnt != sv_before) $display("FAIL mid_no_sample: got %0d pulses want 0", sv_cnt - sv_before); else n_pass++;
    n_checks++; if (joy_x !== 10'd512) $display("FAIL mid_after_joy_x: got %0d want 512", joy_x); else n_pass++;
  endtask

  task automatic test_after_reset();
    bit ok;
    int sv_before;
    logic [22:0] exp;
    next_frame = make_frame(10'h155, 10'h2AA, 3'b010, 1'b1);
    exp_q.push_back({10'd341, 10'd682, 3'd2});
    sv_before = sv_cnt;
    wait_ss_fall(POLL_PERIOD + 100, ok);
    n_checks++; if (!ok) $display("FAIL after_ss_fall: got timeout want ss fall"); else n_pass++;
    wait_sample(20000, ok);
    n_checks++; if (!ok) $display("FAIL after_sample: got timeout want sample_valid"); else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL after_queue: got empty want 1 entry");
    end else begin
      n_pass++;
      exp = exp_q.pop_front();
      n_checks++; if (joy_x !== exp[22:13]) $display("FAIL after_joy_x: got %0d want %0d", joy_x, exp[22:13]); else n_pass++;
      n_checks++; if (joy_y !== exp[12:3]) $display("FAIL after_joy_y: got %0d want %0d", joy_y, exp[12:3]); else n_pass++;
      n_checks++; if (btn !== exp[2:0]) $display("FAIL after_btn: got %0d want %0d", btn, exp[2:0]); else n_pass++;
    end
    n_txn++;
    $display("txn %0d: joy_x=%0d joy_y=%0d btn=%0d", n_txn, joy_x, joy_y, btn);
    tick();
    n_checks++; if (txn_rises != 40) $display("FAIL after_rises: got %0d want 40", txn_rises); else n_pass++;
    n_checks++; if (sv_cnt - sv_before != 1) $display("FAIL after_sv_count: got %0d want 1", sv_cnt - sv_before); else n_pass++;
    n_checks++; if (mosi_sr[39:32] !== 8'h81) $display("FAIL after_mosi_b0: got %h want 81", mosi_sr[39:32]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_transaction();
    test_back_to_back();
    test_reset_mid();
    test_after_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
